car_sensor_cond: RTL

//  Conditions the raw E/W road vehicle sensor (loop/switch) into the clean, latched car_detected

---
 rtl/car_sensor_cond_pkg.sv | 23 ++
 rtl/car_sensor_cond_sig_debounce.sv | 44 ++++
 rtl/car_sensor_cond.sv | 93 +++++++++
 3 files changed

// File: rtl/car_sensor_cond_pkg.sv
// Shared types and encodings for the E/W vehicle sensor conditioner and its neighbours.
// The lights_out field codes match the intersection controller so the top level can decode ew_green.
package car_sensor_cond_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_QUALIFY  = 2'd1,
        ST_REQUEST  = 2'd2,
        ST_SERVICED = 2'd3
    } req_state_e;

    localparam int SYNC_STAGES = 2;

    // lights_out = {ns_light[1:0], ew_light[1:0]}
    localparam logic [1:0] LIGHT_RED    = 2'd0;
    localparam logic [1:0] LIGHT_YELLOW = 2'd1;
    localparam logic [1:0] LIGHT_GREEN  = 2'd2;

    function automatic logic ew_is_green(input logic [3:0] lights_out);
        return (lights_out[1:0] == LIGHT_GREEN);
    endfunction

endpackage

// File: rtl/car_sensor_cond_sig_debounce.sv
// Two-flop synchroniser followed by a stability counter; the output only follows the input
// after it has differed for DEBOUNCE_CYCLES consecutive cycles. Reusable for pushbuttons.
module sig_debounce
    import car_sensor_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 21
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_din,
    output logic o_dout
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_dout;
    logic                   w_s_sync;

    assign w_s_sync = r_sync[SYNC_STAGES-1];
    assign o_dout   = r_dout;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_dout <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
            // Any return to the current level restarts the count, so it can never wrap.
            if (w_s_sync == r_dout) begin
                r_cnt <= '0;
            end else if (r_cnt == LP_CNT_LAST) begin
                r_dout <= w_s_sync;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/car_sensor_cond.sv
// Turns the raw E/W loop sensor into a latched car_detected request for the intersection
// controller: debounce, qualify presence for MIN_PRESENT_CYCLES, hold until E/W green, re-arm.
module car_sensor_cond
    import car_sensor_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = 500000,
    parameter int MIN_PRESENT_CYCLES = 1000000,
    parameter int CNT_W              = 21
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_sensor_raw,
    input  logic       i_ew_green,
    output logic       o_car_detected,
    output logic       o_sensor_clean,
    output logic [1:0] o_req_state
);

    localparam logic [CNT_W-1:0] LP_PRES_LAST = CNT_W'(MIN_PRESENT_CYCLES - 1);

    req_state_e       r_state;
    req_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_pres_cnt;
    logic [CNT_W-1:0] w_pres_nxt;
    logic             r_car;
    logic             w_clean;

    sig_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_din     (i_sensor_raw),
        .o_dout    (w_clean)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pres_nxt  = r_pres_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_clean) begin
                    w_state_nxt = ST_QUALIFY;
                    w_pres_nxt  = '0;
                end
            end
            ST_QUALIFY: begin
                // Car leaving beats a green already showing, which beats qualification expiry.
                if (!w_clean) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_ew_green) begin
                    w_state_nxt = ST_SERVICED;
                end else if (r_pres_cnt == LP_PRES_LAST) begin
                    w_state_nxt = ST_REQUEST;
                end else begin
                    w_pres_nxt = r_pres_cnt + 1'b1;
                end
            end
            ST_REQUEST: begin
                if (i_ew_green) begin
                    w_state_nxt = ST_SERVICED;
                end
            end
            ST_SERVICED: begin
                if (!w_clean && !i_ew_green) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_pres_cnt <= '0;
            r_car      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pres_cnt <= w_pres_nxt;
            // Registered from next state so it tracks REQUEST with no extra cycle of lag.
            r_car      <= (w_state_nxt == ST_REQUEST);
        end
    end

    assign o_car_detected = r_car;
    assign o_sensor_clean = w_clean;
    assign o_req_state    = r_state;

endmodule
